// File: rtl/game_timer_if.sv
// Controller <-> game timer signal bundle: enable/reconfig/bonus requests in,
// timeout/running status and BCD seconds out.
interface game_timer_if;
  logic       i_timerEn;
  logic       i_timerReconfig;
  logic       i_addPls;
  logic       o_timeOut;
  logic       o_running;
  logic [3:0] o_secTens;
  logic [3:0] o_secOnes;

  modport slave (
    input  i_timerEn, i_timerReconfig, i_addPls,
    output o_timeOut, o_running, o_secTens, o_secOnes
  );

  modport master (
    output i_timerEn, i_timerReconfig, i_addPls,
    input  o_timeOut, o_running, o_secTens, o_secOnes
  );
endinterface

// File: rtl/game_timer.sv
// Countdown round timer (0..99 s) with a BCD display feed and a sticky timeout.
// Define BONUS_EN to let addPls add BONUS_SECS (saturating at 99) while counting.
module game_timer #(
  parameter int START_SECS = 60,
  parameter int TICK_DIV   = 50000000,
  parameter int BONUS_SECS = 5
) (
  input logic          clk,
  input logic          rst,
  game_timer_if.slave  bus
);

  localparam int             PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]     START   = 7'(START_SECS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state, w_nextState;
  logic [6:0]    r_count, w_nextCount, w_decCount;
  logic [PW-1:0] r_pre, w_nextPre;
  logic          r_timeOut, r_running;
  logic          w_tick;

  assign w_tick     = (r_pre == PRE_MAX);
  assign w_decCount = (w_tick && (r_count != 7'd0)) ? r_count - 7'd1 : r_count;

`ifdef BONUS_EN
  function automatic logic [6:0] addBonus(input logic [6:0] c);
    logic [7:0] sum;
    sum = {1'b0, c} + 8'(BONUS_SECS);
    return (sum > 8'd99) ? 7'd99 : sum[6:0];
  endfunction
`else
  logic w_unusedAddPls;
  assign w_unusedAddPls = bus.i_addPls;
`endif

  // Reconfig beats every state; a tick that also takes a bonus is folded into one update.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextPre   = r_pre;
    if (bus.i_timerReconfig) begin
      w_nextState = IDLE;
      w_nextCount = START;
      w_nextPre   = '0;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef BONUS_EN
          if (bus.i_addPls) w_nextCount = addBonus(r_count);
`endif
          if (bus.i_timerEn) w_nextState = (w_nextCount != 7'd0) ? RUN : DONE;
        end
        RUN: begin
          if (!bus.i_timerEn) begin
            w_nextState = IDLE;
`ifdef BONUS_EN
            if (bus.i_addPls) w_nextCount = addBonus(r_count);
`endif
          end else begin
            w_nextPre   = w_tick ? '0 : r_pre + 1'b1;
            w_nextCount = w_decCount;
`ifdef BONUS_EN
            if (bus.i_addPls) w_nextCount = addBonus(w_decCount);
`endif
            if (w_nextCount == 7'd0) w_nextState = DONE;
          end
        end
        DONE: w_nextCount = 7'd0;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= START;
      r_pre     <= '0;
      r_timeOut <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_pre     <= w_nextPre;
      r_timeOut <= (w_nextState == DONE);
      r_running <= (w_nextState == RUN);
    end
  end

  assign bus.o_timeOut = r_timeOut;
  assign bus.o_running = r_running;
  assign bus.o_secTens = 4'(r_count / 7'd10);
  assign bus.o_secOnes = 4'(r_count % 7'd10);

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a vector table drives the START_SECS=3 instance,
// hand sequences cover BCD borrow, zero start and (with BONUS_EN) bonus handling.
module tb_game_timer;

  typedef struct {
    bit         rstN;
    bit         en;
    bit         reconf;
    int         n;
    logic [9:0] exp;
    string      name;
  } vec_t;

  logic clk;
  logic rstA, rstO;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  game_timer_if ifA ();
  game_timer_if ifB ();
  game_timer_if ifC ();
  game_timer_if ifD ();

  game_timer #(.START_SECS(3),  .TICK_DIV(4), .BONUS_SECS(5)) dutA (.clk(clk), .rst(rstA), .bus(ifA.slave));
  game_timer #(.START_SECS(10), .TICK_DIV(4), .BONUS_SECS(5)) dutB (.clk(clk), .rst(rstO), .bus(ifB.slave));
  game_timer #(.START_SECS(0),  .TICK_DIV(4), .BONUS_SECS(5)) dutC (.clk(clk), .rst(rstO), .bus(ifC.slave));
  game_timer #(.START_SECS(97), .TICK_DIV(4), .BONUS_SECS(5)) dutD (.clk(clk), .rst(rstO), .bus(ifD.slave));

  logic [9:0] actA, actB, actC, actD;
  assign actA = {ifA.o_timeOut, ifA.o_running, ifA.o_secTens, ifA.o_secOnes};
  assign actB = {ifB.o_timeOut, ifB.o_running, ifB.o_secTens, ifB.o_secOnes};
  assign actC = {ifC.o_timeOut, ifC.o_running, ifC.o_secTens, ifC.o_secOnes};
  assign actD = {ifD.o_timeOut, ifD.o_running, ifD.o_secTens, ifD.o_secOnes};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] pk(input bit to, input bit run, input int tens, input int ones);
    return {to, run, 4'(tens), 4'(ones)};
  endfunction

  task automatic addVec(input bit rstN, input bit en, input bit reconf, input int n,
                        input bit to, input bit run, input int tens, input int ones,
                        input string name);
    vec_t v;
    v.rstN = rstN; v.en = en; v.reconf = reconf; v.n = n;
    v.exp = pk(to, run, tens, ones); v.name = name;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input bit rstN, input bit en, input bit reconf);
    rstA                = rstN;
    ifA.i_timerEn       = en;
    ifA.i_timerReconfig = reconf;
    ifA.i_addPls        = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got to=%b run=%b digits=%0d/%0d, want to=%b run=%b digits=%0d/%0d",
               name, act[9], act[8], act[7:4], act[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstA = 1'b0; rstO = 1'b0;
    ifA.i_timerEn = 1'b0; ifA.i_timerReconfig = 1'b0; ifA.i_addPls = 1'b0;
    ifB.i_timerEn = 1'b0; ifB.i_timerReconfig = 1'b0; ifB.i_addPls = 1'b0;
    ifC.i_timerEn = 1'b0; ifC.i_timerReconfig = 1'b0; ifC.i_addPls = 1'b0;
    ifD.i_timerEn = 1'b0; ifD.i_timerReconfig = 1'b0; ifD.i_addPls = 1'b0;

    // rstN en reconf cycles | to run tens ones
    addVec(1, 0, 1, 1,  0, 0, 0, 3, "reconfigIdle");
    addVec(1, 1, 0, 1,  0, 1, 0, 3, "enterRun");
    addVec(1, 1, 0, 3,  0, 1, 0, 3, "preTick1");
    addVec(1, 1, 0, 1,  0, 1, 0, 2, "tick1");
    addVec(1, 1, 0, 3,  0, 1, 0, 2, "preTick2");
    addVec(1, 1, 0, 1,  0, 1, 0, 1, "tick2");
    addVec(1, 1, 0, 3,  0, 1, 0, 1, "preTick3");
    addVec(1, 1, 0, 1,  1, 0, 0, 0, "reachZero");
    addVec(1, 1, 0, 20, 1, 0, 0, 0, "timeoutHeld");
    addVec(1, 1, 1, 1,  0, 0, 0, 3, "reconfigFromDone");
    addVec(1, 1, 1, 5,  0, 0, 0, 3, "reconfigBlocksRun");
    addVec(1, 0, 0, 1,  0, 0, 0, 3, "idleAfterReconfig");
    addVec(1, 1, 0, 1,  0, 1, 0, 3, "reenterRun");
    addVec(1, 1, 0, 2,  0, 1, 0, 3, "twoRunCycles");
    addVec(1, 0, 0, 1,  0, 0, 0, 3, "pauseEnter");
    addVec(1, 0, 0, 9,  0, 0, 0, 3, "pauseHold");
    addVec(1, 1, 0, 1,  0, 1, 0, 3, "resume");
    addVec(1, 1, 0, 1,  0, 1, 0, 3, "resumeRun1");
    addVec(1, 1, 0, 1,  0, 1, 0, 2, "resumeTick");
    addVec(1, 1, 0, 7,  0, 1, 0, 1, "count1Pre3");
    addVec(0, 1, 0, 1,  0, 0, 0, 3, "resetMidRun");
    addVec(1, 0, 0, 1,  0, 0, 0, 3, "noPendingTick");

    cyc(2);
    checkOutput("resetA", actA, pk(0, 0, 0, 3));
    checkOutput("resetB", actB, pk(0, 0, 1, 0));
    checkOutput("resetC", actC, pk(0, 0, 0, 0));
    checkOutput("resetD", actD, pk(0, 0, 9, 7));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].reconf);
      cyc(vecs[i].n);
      checkOutput(vecs[i].name, actA, vecs[i].exp);
    end

    // BCD borrow from 10 and immediate timeout when starting at zero
    rstO = 1'b1;
    ifB.i_timerEn = 1'b1;
    ifC.i_timerEn = 1'b1;
    cyc(1);
    checkOutput("bEnterRun", actB, pk(0, 1, 1, 0));
    checkOutput("cZeroStartDone", actC, pk(1, 0, 0, 0));
    cyc(4);
    checkOutput("bBcdBorrow", actB, pk(0, 1, 0, 9));
    checkOutput("cDoneHeld", actC, pk(1, 0, 0, 0));

`ifdef BONUS_EN
    ifD.i_addPls = 1'b1;
    cyc(1);
    checkOutput("dBonusSaturate", actD, pk(0, 0, 9, 9));
    ifD.i_addPls = 1'b0;
    ifD.i_timerEn = 1'b1;
    cyc(1);
    checkOutput("dEnterRun", actD, pk(0, 1, 9, 9));
    cyc(388);
    checkOutput("dCountTo2", actD, pk(0, 1, 0, 2));
    cyc(3);
    ifD.i_addPls = 1'b1;
    cyc(1);
    checkOutput("dTickPlusBonus", actD, pk(0, 1, 0, 6));
    ifD.i_addPls = 1'b0;
    cyc(24);
    checkOutput("dReachDone", actD, pk(1, 0, 0, 0));
    ifD.i_addPls = 1'b1;
    cyc(1);
    checkOutput("dBonusInDone", actD, pk(1, 0, 0, 0));
    ifD.i_addPls = 1'b0;
`else
    ifD.i_addPls = 1'b1;
    cyc(2);
    checkOutput("dAddIgnored", actD, pk(0, 0, 9, 7));
    ifD.i_addPls = 1'b0;
    ifD.i_timerEn = 1'b1;
    cyc(1);
    checkOutput("dEnterRun", actD, pk(0, 1, 9, 7));
    cyc(4);
    checkOutput("dTick97", actD, pk(0, 1, 9, 6));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
Countdown game timer. It consumes the game controller's timerEn and timerReconfig outputs and produces the timeOut input that ends a round.
- Holds remaining seconds (0..99) and shows them as two BCD digits on the score/time display.
- Decrements once per TICK_DIV clock cycles while enabled.
- Raises a level timeOut when the count reaches zero.

Parameters:
START_SECS, 60, seconds loaded on reset/reconfig; legal 0..99.
TICK_DIV, 50000000, clk cycles per second tick; legal >= 2.
BONUS_SECS, 5, seconds added per addPls (BONUS_EN only); legal 0..99.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
timerEn  in  1  level; count while high
timerReconfig  in  1  level; reload START_SECS, clear timeout
addPls  in  1  one-cycle bonus request (ignored unless BONUS_EN)
timeOut  out  1  high while in DONE state
running  out  1  high while in RUN state
secTens  out  4  BCD tens of remaining seconds
secOnes  out  4  BCD ones of remaining seconds

Behaviour:
- Reset: clock is clk; reset is rst, synchronous, active-low.
  - Reset values: state IDLE, count=START_SECS, prescaler=0, timeOut=0, running=0.
- Internal state:
  - 7-bit binary count.
  - Prescaler 0..TICK_DIV-1.
  - secTens = count/10 and secOnes = count%10, combinational from the registered count.
- Priority each clk edge: rst low > timerReconfig > state logic.
- timerReconfig=1, any state: next state IDLE, count=START_SECS, prescaler=0, timeOut=0.
  - While held high, the block stays in IDLE regardless of timerEn.
- States and transitions:
  - IDLE: timerEn=1 and count>0 -> RUN. timerEn=1 and count=0 -> DONE on the next edge.
  - RUN:
    - Prescaler increments each cycle.
    - tick = (prescaler==TICK_DIV-1); on tick the prescaler returns to 0 and count decrements by 1.
    - A tick that makes count 0 -> DONE.
    - timerEn=0 -> IDLE. Prescaler and count are retained (pause); resuming continues from the retained prescaler.
  - DONE: count frozen at 0, timeOut=1, running=0. timerEn is ignored; only reconfig or reset leaves DONE.
- First-second timing: the first decrement occurs exactly TICK_DIV cycles after the first RUN cycle.
- timeOut is registered. It rises the cycle count reaches 0 and stays high until reconfig, so a controller that misses one cycle still sees it.
- running = (state==RUN), registered with state.
- No underflow: count never decrements below 0.
- Reset mid-run overrides everything; no pending tick survives.

Optional Feature:
BONUS_EN:
- Defined: addPls=1 in IDLE or RUN adds BONUS_SECS to count, saturating at 99.
  - Simultaneous tick and addPls: new count = min(count-1+BONUS_SECS, 99).
  - If that result is 0, go to DONE.
  - addPls in DONE, or with timerReconfig high, is ignored.
  - The prescaler is not affected by addPls.
- Undefined: addPls is unused (no logic) and count changes only by tick/reload.

Test Plan:
1. START_SECS=3, TICK_DIV=4; release rst, timerReconfig 1 cycle, then timerEn=1:
   - secTens/secOnes=0/3 and running=1 after entry.
   - Count shows 2, 1, 0 at RUN cycles 4, 8, 12.
   - timeOut=1 from the cycle count=0 and held for 20 further cycles with timerEn still high.
2. Pause: TICK_DIV=4, drop timerEn after 2 RUN cycles and hold low 10 cycles:
   - count unchanged and running=0 while low.
   - After re-raising, decrement occurs after 2 more RUN cycles.
3. From DONE, pulse timerReconfig:
   - Next cycle timeOut=0, count=START_SECS (0/3), state IDLE.
   - With timerReconfig and timerEn both high, no counting occurs.
4. START_SECS=10, TICK_DIV=4: after the first tick, digits 0/9 (BCD borrow); START_SECS=0 plus timerEn -> timeOut=1 one cycle later.
5. BONUS_EN, BONUS_SECS=5:
   - At count 97, addPls -> 99 (saturated).
   - At count 2, addPls on the tick cycle -> 6.
   - addPls in DONE -> count stays 0.
6. Assert rst low mid-RUN (count 1, prescaler 3): next cycle count=START_SECS, running=0, timeOut=0, and no decrement is applied.
